// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the three-requester memory port arbiter
package mem_arb_pkg;
    localparam int NUM_REQ = 3;
    typedef logic [1:0] req_idx_t;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    function automatic req_idx_t next_idx(req_idx_t i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter_3.sv
// rr_arbiter_3: combinational three-way round-robin pick starting after last_grant
module rr_arbiter_3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);
    req_idx_t p0, p1, p2;
    always_comb begin
        p0 = next_idx(last_grant);
        p1 = next_idx(p0);
        p2 = next_idx(p1);
        grant_valid = |req;
        grant_idx = req[p0] ? p0 : req[p1] ? p1 : p2;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer sharing one single-port memory among three requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [2:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_sel
);
    localparam int CNT_W = $clog2(8) + 1;
    arb_state_t       state;
    req_idx_t         last_grant;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic [1:0]       grant_idx;

    rr_arbiter_3 u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign req_ready = (state == IDLE && grant_valid) ? 3'(1) << grant_idx : 3'b000;

    // resp_sel doubles as the owner index of the transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd2;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_sel   <= '0;
        end else begin
            mem_en     <= 1'b0;
            resp_valid <= '0;
            case (state)
                IDLE: if (grant_valid) begin
                    state      <= ACCESS;
                    last_grant <= grant_idx;
                    resp_sel   <= grant_idx;
                    mem_en     <= 1'b1;
                    mem_we     <= req_we[grant_idx];
                    mem_addr   <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                    mem_wdata  <= req_wdata[grant_idx*DATA_W +: DATA_W];
                end
                ACCESS: begin
                    state <= mem_we ? IDLE : WAIT;
                    cnt   <= CNT_W'(RD_LATENCY - 1);
                end
                WAIT: if (cnt == '0) begin
                    state      <= RESP;
                    resp_rdata <= mem_rdata;
                    resp_valid <= 3'(1) << resp_sel;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: latency 1/2/8 variants checked against a transaction-timeline model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req_valid = '0, req_we = '0;
    logic [47:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  rdy [3];
    logic        en [3], mwe_o [3];
    logic [15:0] maddr_o [3], mwd_o [3], mrd [3], rrd_o [3];
    logic [2:0]  rv_o [3];
    logic [1:0]  sel_o [3];
    int passed = 0, total = 0, cyc = 0;
    bit chk_on = 1'b0;

    function automatic int lat(int i);
        return i == 0 ? 1 : i == 1 ? 2 : 8;
    endfunction

    function automatic logic [15:0] mem_val(logic [15:0] a);
        return a == 16'h0040 ? 16'hBEEF : a ^ 16'h5A3C;
    endfunction

    function automatic int rr(logic [2:0] v, int last);
        for (int k = 1; k <= 3; k++) if (v[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LATENCY(g == 0 ? 1 : g == 1 ? 2 : 8)) dut (
            .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[g]), .req_we(req_we),
            .req_addr(req_addr), .req_wdata(req_wdata), .mem_en(en[g]), .mem_we(mwe_o[g]),
            .mem_addr(maddr_o[g]), .mem_wdata(mwd_o[g]), .mem_rdata(mrd[g]),
            .resp_valid(rv_o[g]), .resp_rdata(rrd_o[g]), .resp_sel(sel_o[g])
        );
    end

    task automatic check(string n, int i, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s L=%0d cyc=%0d got=%0h exp=%0h", n, lat(i), cyc, got, exp);
    endtask

    // memory: read data is valid only during the cycle RD_LATENCY after mem_en
    bit iv [3];
    int ic [3];
    logic [15:0] ia [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i] === 1'b1 && mwe_o[i] === 1'b0) begin
                iv[i] = 1'b1;
                ic[i] = cyc;
                ia[i] = maddr_o[i];
            end
            mrd[i] = (iv[i] && cyc == ic[i] + lat(i)) ? mem_val(ia[i]) : 16'hDEAD;
        end
    end

    // transaction model: one record per variant, outputs derived from cycles since accept
    bit busy [3], twe [3], emwe [3];
    int t0 [3], own [3], last [3], esel [3];
    logic [15:0] taddr [3], emaddr [3], emwd [3], erd [3];
    always @(posedge clk) begin : mdl
        int w, ph;
        for (int i = 0; i < 3; i++) begin
            w = rr(req_valid, last[i]);
            ph = cyc - t0[i];
            if (rst) begin
                busy[i] = 0; last[i] = 2; esel[i] = 0; erd[i] = '0;
                emwe[i] = 0; emaddr[i] = '0; emwd[i] = '0;
            end else if (!busy[i]) begin
                if (w >= 0) begin
                    busy[i] = 1; t0[i] = cyc; own[i] = w; last[i] = w; esel[i] = w;
                    twe[i] = req_we[w]; taddr[i] = req_addr[w*16 +: 16];
                    emwe[i] = req_we[w]; emaddr[i] = taddr[i]; emwd[i] = req_wdata[w*16 +: 16];
                end
            end else begin
                if (!twe[i] && ph == lat(i) + 1) erd[i] = mem_val(taddr[i]);
                if (twe[i] ? ph == 1 : ph == lat(i) + 2) busy[i] = 0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : cmp
        int ph, w;
        logic [2:0] erdy, erv;
        if (chk_on && !rst) begin
            for (int i = 0; i < 3; i++) begin
                ph = cyc - t0[i];
                w = rr(req_valid, last[i]);
                erdy = (!busy[i] && w >= 0) ? 3'(1) << w : 3'b000;
                erv = (busy[i] && !twe[i] && ph == lat(i) + 2) ? 3'(1) << own[i] : 3'b000;
                check("req_ready", i, rdy[i], erdy);
                check("mem_en", i, en[i], busy[i] && ph == 1);
                check("mem_we", i, mwe_o[i], emwe[i]);
                check("mem_addr", i, maddr_o[i], emaddr[i]);
                check("mem_wdata", i, mwd_o[i], emwd[i]);
                check("resp_valid", i, rv_o[i], erv);
                check("resp_rdata", i, rrd_o[i], erd[i]);
                check("resp_sel", i, sel_o[i], esel[i]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wd_tab [3] = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    int ord [4] = '{0, 1, 2, 0};

    initial begin
        nxt(); nxt();
        rst = 1'b0; chk_on = 1'b1;
        @(negedge clk);
        check("rst_en", 1, en[1], 0);
        check("rst_addr", 1, maddr_o[1], 0);
        check("rst_resp", 1, rv_o[1], 0);
        check("rst_rdata", 1, rrd_o[1], 0);
        check("rst_sel", 1, sel_o[1], 0);
        // single read by requester 1
        nxt();
        req_valid = 3'b010; req_we = 3'b000; req_addr = {16'h0000, 16'h0040, 16'h0000};
        @(negedge clk); check("t1_ready", 1, rdy[1], 3'b010);
        nxt(); req_valid = 3'b000;
        @(negedge clk);
        check("t1_en", 1, en[1], 1);
        check("t1_we", 1, mwe_o[1], 0);
        check("t1_addr", 1, maddr_o[1], 16'h0040);
        nxt(); @(negedge clk);
        nxt(); @(negedge clk);
        check("t1_l1_resp", 0, rv_o[0], 3'b010);
        check("t1_l2_early", 1, rv_o[1], 3'b000);
        nxt(); @(negedge clk);
        check("t1_resp", 1, rv_o[1], 3'b010);
        check("t1_rdata", 1, rrd_o[1], 16'hBEEF);
        check("t1_sel", 1, sel_o[1], 1);
        for (int c = 5; c <= 11; c++) begin
            nxt(); @(negedge clk);
            check("t1_l8_resp", 2, rv_o[2], c == 10 ? 3'b010 : 3'b000);
        end
        // latency sweep: requester 2 read while requester 0 keeps asking
        nxt();
        req_valid = 3'b100; req_addr = {16'h1230, 16'h0040, 16'h0010};
        @(negedge clk); check("t4_ready", 2, rdy[2], 3'b100);
        for (int c = 1; c <= 10; c++) begin
            nxt(); req_valid = 3'b001;
            @(negedge clk);
            check("t4_l8_ready", 2, rdy[2], 3'b000);
            check("t4_l8_resp", 2, rv_o[2], c == 10 ? 3'b100 : 3'b000);
            if (c == 3) check("t4_l1_resp", 0, rv_o[0], 3'b100);
        end
        check("t4_l8_rdata", 2, rrd_o[2], 16'h480C);
        // three writes held from reset
        nxt();
        rst = 1'b1; req_valid = 3'b111; req_we = 3'b111;
        req_addr = {16'h0300, 16'h0200, 16'h0100}; req_wdata = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        nxt(); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t2_ready", 1, rdy[1], c % 2 == 0 ? 3'(1) << ord[c/2] : 3'b000);
            if (c % 2 == 1) check("t2_wdata", 1, mwd_o[1], wd_tab[ord[c/2]]);
            check("t2_resp", 1, rv_o[1], 3'b000);
            nxt();
        end
        // fairness: requester 2 arrives after requester 0's first grant
        rst = 1'b1; req_valid = 3'b001;
        nxt(); rst = 1'b0;
        @(negedge clk); check("t3_first", 1, rdy[1], 3'b001);
        nxt(); req_valid = 3'b101;
        @(negedge clk); check("t3_busy", 1, rdy[1], 3'b000);
        nxt(); @(negedge clk); check("t3_second", 1, rdy[1], 3'b100);
        nxt(); @(negedge clk);
        check("t3_wdata", 1, mwd_o[1], 16'hC2C2);
        check("t3_sel", 1, sel_o[1], 2);
        nxt(); @(negedge clk); check("t3_third", 1, rdy[1], 3'b001);
        // reset during WAIT of a read by requester 0
        nxt(); rst = 1'b1; req_valid = 3'b000;
        nxt(); rst = 1'b0;
        req_valid = 3'b001; req_we = 3'b000; req_addr = {16'h0300, 16'h0200, 16'h0077};
        @(negedge clk); check("t5_ready", 1, rdy[1], 3'b001);
        nxt(); req_valid = 3'b000;
        @(negedge clk); check("t5_en", 1, en[1], 1);
        nxt(); rst = 1'b1;
        @(negedge clk);
        nxt(); rst = 1'b0; req_valid = 3'b011; req_we = 3'b011;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("t5_rst_en", i, en[i], 0);
            check("t5_rst_addr", i, maddr_o[i], 0);
            check("t5_rst_resp", i, rv_o[i], 0);
            check("t5_rst_sel", i, sel_o[i], 0);
            check("t5_winner", i, rdy[i], 3'b001);
        end
        for (int c = 4; c <= 12; c++) begin
            nxt(); req_valid = 3'b000;
            @(negedge clk);
            for (int i = 0; i < 3; i++) check("t5_no_resp", i, rv_o[i], 3'b000);
        end
        // withdrawn request pulses while every variant is in WAIT
        nxt();
        req_valid = 3'b010; req_we = 3'b000; req_addr = {16'h0500, 16'h0040, 16'h0000};
        @(negedge clk); check("t6_ready", 1, rdy[1], 3'b010);
        nxt(); req_valid = 3'b000;
        nxt(); req_valid = 3'b100;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("t6_wait_ready", i, rdy[i], 3'b000);
        for (int c = 3; c <= 12; c++) begin
            nxt(); req_valid = 3'b000;
            @(negedge clk);
            check("t6_never2", 2, rdy[2], 3'b000);
        end
        check("t6_sel", 1, sel_o[1], 1);
        // mixed traffic with occasional resets
        for (int c = 0; c < 300; c++) begin
            nxt();
            rst = ($urandom_range(0, 60) == 0);
            req_valid = 3'($urandom); req_we = 3'($urandom);
            req_addr = {16'($urandom), 16'($urandom), 16'($urandom)};
            req_wdata = {16'($urandom), 16'($urandom), 16'($urandom)};
        end
        nxt(); rst = 1'b0; req_valid = 3'b000;
        nxt(); nxt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and access sequencer sharing one single-port 16-bit memory between three requesters. Each IDLE cycle it grants one pending requester, issues one memory access, waits out the fixed read latency, and returns read data with a 2-bit return select. That select drives the 1-to-3 return-data demultiplexer in the CPU memory path. One transaction is in flight at a time.

## Interface
- DATA_W, 16, data width
- ADDR_W, 16, address width
- RD_LATENCY, 2, memory cycles from mem_en to valid mem_rdata; legal range 1..8
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  3  per-requester request pending
- req_ready  out  3  per-requester accept strobe, one-hot or zero
- req_we  in  3  per-requester write (1) / read (0)
- req_addr  in  3×ADDR_W  per-requester address
- req_wdata  in  3×DATA_W  per-requester write data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- resp_valid  out  3  one-cycle read-response pulse to the owning requester
- resp_rdata  out  DATA_W  registered read data
- resp_sel  out  2  index of current/last owner (0..2); never 2'b11

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Rotating-priority search starts at (last_grant+1) mod 3; the winner is the first requester with req_valid=1.
  - req_ready[winner]=1 combinationally in that cycle; the handshake completes in the same cycle.
  - On a grant, latch index, we, addr and wdata; last_grant<=winner; go to ACCESS.
  - No grant if req_valid==0. req_ready is 0 in every other state.
  - req_valid may drop without a grant; arbitration is re-evaluated every IDLE cycle.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches.
  - Write: go to IDLE; no response.
  - Read: load the latency counter with RD_LATENCY-1; go to WAIT.
- WAIT:
  - mem_en=0. Decrement the counter.
  - When it is 0, sample mem_rdata into resp_rdata; go to RESP.
- RESP: resp_valid[owner]=1 for exactly one cycle; go to IDLE. There is no response backpressure.
- resp_sel:
  - Updates to the winner on grant and holds until the next grant.
  - resp_rdata holds until the next read sample.
- mem_addr/mem_wdata/mem_we hold latched values outside ACCESS; only mem_en qualifies them.

## Timing
- Reset values: state=IDLE, last_grant=2 (requester 0 has first priority), req_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_sel=0, counter=0.
- Accept in cycle 0 → mem_en in cycle 1.
- Write: the next accept is possible in cycle 2; throughput is one write per 2 cycles.
- Read:
  - mem_rdata is sampled at the end of cycle 1+RD_LATENCY.
  - resp_valid is asserted in cycle 2+RD_LATENCY.
  - The next accept is possible in cycle 3+RD_LATENCY.
- Simultaneous requests: the rotating priority guarantees no requester waits more than 2 grants.
- Reset asserted mid-transaction: the transaction is abandoned. All outputs take reset values at that edge, and no resp_valid is produced for it.
- A request arriving during ACCESS/WAIT/RESP waits; req_ready stays 0.

## Structure
- Package mem_arb_pkg:
  - NUM_REQ=3
  - typedef req_idx_t (logic [1:0])
  - typedef arb_state_t enum {IDLE, ACCESS, WAIT, RESP}
  - function next_idx (mod-3 increment)
- Sub-module rr_arbiter_3: combinational; inputs req[2:0] and last_grant; outputs grant_valid and grant_idx. It is reusable for other shared resources.
- Top level holds the FSM, the transaction latches, the latency counter ($clog2(8)+1 bits) and the response registers.

## Test plan
- Single read, RD_LATENCY=2:
  - Stimulus: req_valid=3'b010, addr=16'h0040, memory model returns 16'hBEEF.
  - Required: req_ready[1] at cycle 0; mem_en=1, we=0, addr=0x0040 at cycle 1; resp_valid=3'b010, resp_rdata=16'hBEEF, resp_sel=1 at cycle 4.
- Three simultaneous writes held continuously from reset:
  - Required: grants in order 0,1,2,0 at cycles 0,2,4,6; mem_wdata matches each requester; no resp_valid.
- Fairness:
  - Stimulus: requester 0 always valid, requester 2 raises valid after the first grant.
  - Required: the second grant goes to 2, not 0.
- Latency sweep, RD_LATENCY=1 and 8:
  - Required: resp_valid exactly 3 and 10 cycles after accept; req_ready stays 0 throughout.
- Reset during WAIT (rst=1 for one cycle, cycle 2 of a read):
  - Required: all outputs at reset values the next cycle; no resp_valid; requester 0 wins the next arbitration.
- Withdrawn request:
  - Stimulus: req_valid[2] pulses for one cycle while the FSM is in WAIT.
  - Required: never granted; req_ready[2] stays 0.
